hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller that sits beside the forwarding unit and decides, each cycle, whether the 5-stage ARM pipeline runs, stalls ID with an EXE bubble, freezes entirely for a slow SRAM access, or flushes on a taken branch. It detects data hazards that forwarding cannot resolve. It tracks multi-cycle memory waits with a state machine and timeout, and keeps saturating stall statistics.

Parameters:
REG_ADDR_W, 4, register address width (matches `REG_ADDRESS_LEN)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_timeout is raised
CNT_W, 16, width of stall statistic counters

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous reset, active-high
en_forwarding  input  1  forwarding enabled
ID_valid  input  1  ID stage holds a real instruction
ID_src1  input  REG_ADDR_W  ID source register 1
ID_src2  input  REG_ADDR_W  ID source register 2
ID_two_src  input  1  ID instruction reads src2
EXE_dst  input  REG_ADDR_W  EXE destination
EXE_wb_en  input  1  EXE will write back
EXE_mem_r_en  input  1  EXE instruction is a load
MEM_dst  input  REG_ADDR_W  MEM destination
MEM_wb_en  input  1  MEM will write back
mem_req  input  1  MEM stage issuing SRAM read/write this cycle
sram_ready  input  1  SRAM completes access this cycle
branch_taken  input  1  taken branch resolved in EXE
hold_if_id  output  1  hold PC and IF/ID register
bubble_exe  output  1  load NOP into ID/EXE register
freeze_all  output  1  hold every pipeline register
flush  output  1  clear IF/ID and ID/EXE
mem_timeout  output  1  sticky error: SRAM wait exceeded MEM_TIMEOUT
hazard_stalls  output  CNT_W  cycles with bubble_exe asserted, saturating
mem_stalls  output  CNT_W  cycles with freeze_all asserted, saturating

Behaviour:
- Reset: state=RUN. Wait counter, hazard_stalls, mem_stalls and mem_timeout are 0. All control outputs are 0 while rst=1, regardless of inputs.
- Match functions (combinational):
  - m_exe = EXE_wb_en && (EXE_dst==ID_src1 || (ID_two_src && EXE_dst==ID_src2))
  - m_mem is the same form using MEM_*.
- Data hazard (combinational):
  - With en_forwarding=1: hz = ID_valid && m_exe && EXE_mem_r_en. This is load-use only.
  - With en_forwarding=0: hz = ID_valid && (m_exe || m_mem).
- States: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req && !sram_ready.
  - MEM_WAIT -> RUN on the cycle sram_ready=1.
  - mem_req is ignored while in MEM_WAIT; the frozen MEM stage keeps it asserted.
- freeze_all = (RUN && mem_req && !sram_ready) || (MEM_WAIT && !sram_ready). It is combinational, with zero-cycle latency. When sram_ready=1, freeze_all=0 that same cycle.
- Output priority, highest first:
  - freeze_all=1 forces hold_if_id=0, bubble_exe=0, flush=0. The branch stays in EXE while frozen, so the flush re-presents after release.
  - Else branch_taken=1 gives flush=1, hold_if_id=0, bubble_exe=0. The hazard is discarded because the ID instruction is squashed.
  - Else hz=1 gives hold_if_id=1, bubble_exe=1, for exactly the cycles hz holds. Load-use yields exactly one bubble, because the load advances to MEM.
- Wait counter:
  - Increments each cycle in MEM_WAIT with sram_ready=0. It clears on entering RUN.
  - When it reaches MEM_TIMEOUT, mem_timeout is set and stays 1 until rst.
  - The state stays MEM_WAIT; no forced exit.
- Statistics: hazard_stalls increments on every cycle bubble_exe=1, and mem_stalls on every cycle freeze_all=1. Both saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT: returns to RUN next edge, counters clear, and freeze_all drops while rst=1.
- Register address 0 is not special (R0 is general-purpose in ARM).

Test Plan:
- Forwarding on, EXE load R3 (EXE_mem_r_en=1, EXE_wb_en=1, EXE_dst=3), ID_src1=3, ID_valid=1 for one cycle, then the load moves to MEM: hold_if_id=bubble_exe=1 for exactly 1 cycle, hazard_stalls=1. Same case with EXE_mem_r_en=0: no stall.
- Forwarding off, MEM_wb_en=1, MEM_dst=5, ID_two_src=1, ID_src2=5: bubble_exe=1. With ID_two_src=0: bubble_exe=0.
- mem_req=1, sram_ready low for 3 cycles then high: freeze_all=1 for 3 cycles, 0 on the 4th, state back to RUN, mem_stalls=3. With sram_ready=1 immediately: freeze_all never asserts.
- branch_taken=1 with a simultaneous load-use hazard: flush=1, bubble_exe=0. Same case during an SRAM wait: flush=0 until sram_ready, then flush=1 the next cycle the branch is presented.
- MEM_TIMEOUT=4, sram_ready held low: mem_timeout rises after the 4th wait cycle and stays 1 after sram_ready; rst clears it. Assert rst mid-wait: freeze_all=0 and state=RUN.
- CNT_W=4, force 20 hazard cycles: hazard_stalls saturates at 15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: decides run / ID stall + EXE bubble / full freeze /
// flush for the 5-stage pipeline, tracks SRAM waits and keeps stall statistics.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   en_forwarding                    forwarding unit active (only load-use stalls)
//   ID_valid, ID_src1/2, ID_two_src  ID stage operand usage
//   EXE_dst, EXE_wb_en, EXE_mem_r_en EXE producer (and whether it is a load)
//   MEM_dst, MEM_wb_en               MEM producer
//   mem_req, sram_ready              MEM-stage SRAM handshake
//   branch_taken                     taken branch resolved in EXE
//   hold_if_id, bubble_exe           data-hazard stall controls
//   freeze_all, flush                SRAM freeze and branch squash controls
//   mem_timeout                      sticky: SRAM wait reached MEM_TIMEOUT
//   hazard_stalls, mem_stalls        saturating stall-cycle counters
module hazard_stall_controller #(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_forwarding,
    input  logic                  ID_valid,
    input  logic [REG_ADDR_W-1:0] ID_src1,
    input  logic [REG_ADDR_W-1:0] ID_src2,
    input  logic                  ID_two_src,
    input  logic [REG_ADDR_W-1:0] EXE_dst,
    input  logic                  EXE_wb_en,
    input  logic                  EXE_mem_r_en,
    input  logic [REG_ADDR_W-1:0] MEM_dst,
    input  logic                  MEM_wb_en,
    input  logic                  mem_req,
    input  logic                  sram_ready,
    input  logic                  branch_taken,
    output logic                  hold_if_id,
    output logic                  bubble_exe,
    output logic                  freeze_all,
    output logic                  flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      hazard_stalls,
    output logic [CNT_W-1:0]      mem_stalls
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   hazard_stalls_q, hazard_stalls_d;
    logic [CNT_W-1:0]   mem_stalls_q, mem_stalls_d;

    logic m_exe, m_mem, hz;

    always_comb begin
        m_exe = EXE_wb_en &&
                (EXE_dst == ID_src1 || (ID_two_src && EXE_dst == ID_src2));
        m_mem = MEM_wb_en &&
                (MEM_dst == ID_src1 || (ID_two_src && MEM_dst == ID_src2));
        if (en_forwarding) begin
            hz = ID_valid && m_exe && EXE_mem_r_en;
        end else begin
            hz = ID_valid && (m_exe || m_mem);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; mem_req is irrelevant once waiting
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mem_req && !sram_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (sram_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Outputs: freeze beats branch flush beats data-hazard stall
    always_comb begin
        freeze_all = 1'b0;
        flush      = 1'b0;
        bubble_exe = 1'b0;
        hold_if_id = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN:      freeze_all = mem_req && !sram_ready;
                MEM_WAIT: freeze_all = !sram_ready;
                default:  freeze_all = 1'b0;
            endcase
            if (!freeze_all) begin
                if (branch_taken) begin
                    flush = 1'b1;
                end else if (hz) begin
                    bubble_exe = 1'b1;
                    hold_if_id = 1'b1;
                end
            end
        end
    end

    // Wait counter, sticky timeout and saturating statistics
    always_comb begin
        wait_cnt_d      = wait_cnt_q;
        mem_timeout_d   = mem_timeout_q;
        hazard_stalls_d = hazard_stalls_q;
        mem_stalls_d    = mem_stalls_q;

        if (state_q == MEM_WAIT && !sram_ready) begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_d == WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end
        if (state_d == RUN) begin
            wait_cnt_d = '0;
        end

        if (bubble_exe && hazard_stalls_q != '1) begin
            hazard_stalls_d = hazard_stalls_q + 1'b1;
        end
        if (freeze_all && mem_stalls_q != '1) begin
            mem_stalls_d = mem_stalls_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q      <= '0;
            mem_timeout_q   <= 1'b0;
            hazard_stalls_q <= '0;
            mem_stalls_q    <= '0;
        end else begin
            wait_cnt_q      <= wait_cnt_d;
            mem_timeout_q   <= mem_timeout_d;
            hazard_stalls_q <= hazard_stalls_d;
            mem_stalls_q    <= mem_stalls_d;
        end
    end

    assign mem_timeout   = mem_timeout_q;
    assign hazard_stalls = hazard_stalls_q;
    assign mem_stalls    = mem_stalls_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: table vectors, corner sequences and randomized
// traffic against a behavioural model of the stall controller.
module tb_hazard_stall_controller;

    localparam int AW = 4;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          rst;
        logic          fwd;
        logic          idv;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic          two;
        logic [AW-1:0] ed;
        logic          ewb;
        logic          eld;
        logic [AW-1:0] md;
        logic          mwb;
        logic          req;
        logic          rdy;
        logic          br;
    } in_t;

    typedef struct {
        in_t        i;
        logic [3:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en_forwarding, ID_valid, ID_two_src;
    logic [AW-1:0] ID_src1, ID_src2, EXE_dst, MEM_dst;
    logic          EXE_wb_en, EXE_mem_r_en, MEM_wb_en;
    logic          mem_req, sram_ready, branch_taken;
    logic          hold_if_id, bubble_exe, freeze_all, flush, mem_timeout;
    logic [CW-1:0] hazard_stalls, mem_stalls;

    hazard_stall_controller #(
        .REG_ADDR_W (AW),
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_forwarding(en_forwarding),
        .ID_valid     (ID_valid),
        .ID_src1      (ID_src1),
        .ID_src2      (ID_src2),
        .ID_two_src   (ID_two_src),
        .EXE_dst      (EXE_dst),
        .EXE_wb_en    (EXE_wb_en),
        .EXE_mem_r_en (EXE_mem_r_en),
        .MEM_dst      (MEM_dst),
        .MEM_wb_en    (MEM_wb_en),
        .mem_req      (mem_req),
        .sram_ready   (sram_ready),
        .branch_taken (branch_taken),
        .hold_if_id   (hold_if_id),
        .bubble_exe   (bubble_exe),
        .freeze_all   (freeze_all),
        .flush        (flush),
        .mem_timeout  (mem_timeout),
        .hazard_stalls(hazard_stalls),
        .mem_stalls   (mem_stalls)
    );

    int tests = 0;
    int failed = 0;

    // Behavioural reference state
    bit m_waiting = 0;
    int m_wait_cycles = 0;
    bit m_to = 0;
    int m_hs = 0;
    int m_ms = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic in_t mk(bit fwd, bit idv, int s1, int s2, bit two,
                               int ed, bit ewb, bit eld, int md, bit mwb,
                               bit req, bit rdy, bit br);
        in_t v;
        v     = '0;
        v.fwd = fwd;  v.idv = idv;
        v.s1  = AW'(s1); v.s2 = AW'(s2); v.two = two;
        v.ed  = AW'(ed); v.ewb = ewb; v.eld = eld;
        v.md  = AW'(md); v.mwb = mwb;
        v.req = req;  v.rdy = rdy; v.br = br;
        return v;
    endfunction

    task automatic apply(input in_t v);
        rst = v.rst; en_forwarding = v.fwd; ID_valid = v.idv;
        ID_src1 = v.s1; ID_src2 = v.s2; ID_two_src = v.two;
        EXE_dst = v.ed; EXE_wb_en = v.ewb; EXE_mem_r_en = v.eld;
        MEM_dst = v.md; MEM_wb_en = v.mwb;
        mem_req = v.req; sram_ready = v.rdy; branch_taken = v.br;
    endtask

    // One pipeline cycle: drive, compare against the model, clock, update model
    task automatic step(input in_t v, output logic [3:0] ctl);
        bit mx, mm, hz, frz, fl, bub;
        int exp_cnt;
        @(negedge clk);
        apply(v);
        #1;
        mx  = v.ewb && (v.ed == v.s1 || (v.two && v.ed == v.s2));
        mm  = v.mwb && (v.md == v.s1 || (v.two && v.md == v.s2));
        hz  = v.idv && (v.fwd ? (mx && v.eld) : (mx || mm));
        frz = !v.rst && (m_waiting ? !v.rdy : (v.req && !v.rdy));
        fl  = !v.rst && !frz && v.br;
        bub = !v.rst && !frz && !v.br && hz;
        ctl = {hold_if_id, bubble_exe, freeze_all, flush};
        chk("model_ctl", int'(ctl), int'({bub, bub, frz, fl}));
        exp_cnt = (int'(m_to) << (2 * CW)) | (m_hs << CW) | m_ms;
        chk("model_cnt", int'({mem_timeout, hazard_stalls, mem_stalls}),
            exp_cnt);
        @(posedge clk);
        if (v.rst) begin
            m_waiting = 0; m_wait_cycles = 0; m_to = 0; m_hs = 0; m_ms = 0;
        end else begin
            if (bub && m_hs < CMAX) m_hs++;
            if (frz && m_ms < CMAX) m_ms++;
            if (m_waiting) begin
                if (v.rdy) begin
                    m_waiting = 0;
                    m_wait_cycles = 0;
                end else begin
                    m_wait_cycles++;
                    if (m_wait_cycles >= TO) m_to = 1;
                end
            end else if (v.req && !v.rdy) begin
                m_waiting = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_t v;
        logic [3:0] c;
        v = '0;
        v.rst = 1'b1;
        step(v, c);
    endtask

    vec_t tbl[$];
    in_t v, lu;
    logic [3:0] ctl;

    initial begin
        // Unchecked power-on reset so flops leave X before comparisons start
        v = '0;
        v.rst = 1'b1;
        apply(v);
        repeat (2) @(posedge clk);
        #1;

        // Reset dominates every input
        v = mk(1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 1);
        v.rst = 1'b1;
        step(v, ctl);
        chk("rst_ctl", int'(ctl), 0);
        chk("rst_cnt", int'({mem_timeout, hazard_stalls, mem_stalls}), 0);

        // Combinational decode table, all from RUN with no SRAM wait
        tbl.push_back('{mk(1,1,3,0,0,3,1,1,0,0,0,0,0), 4'b1100, "load_use"});
        tbl.push_back('{mk(1,1,3,0,0,3,1,0,0,0,0,0,0), 4'b0000, "fwd_no_ld"});
        tbl.push_back('{mk(0,1,1,5,1,2,0,0,5,1,0,0,0), 4'b1100, "nofwd_mem2"});
        tbl.push_back('{mk(0,1,1,5,0,2,0,0,5,1,0,0,0), 4'b0000, "nofwd_one"});
        tbl.push_back('{mk(1,1,3,0,0,3,1,1,0,0,0,0,1), 4'b0001, "br_over_hz"});
        tbl.push_back('{mk(0,1,7,0,0,7,1,0,0,0,0,0,0), 4'b1100, "nofwd_exe"});
        tbl.push_back('{mk(1,1,7,0,0,7,1,0,0,0,0,0,0), 4'b0000, "fwd_exe"});
        tbl.push_back('{mk(1,0,3,0,0,3,1,1,0,0,0,0,0), 4'b0000, "id_invalid"});
        tbl.push_back('{mk(1,1,0,0,0,0,1,1,0,0,0,0,0), 4'b1100, "r0_hazard"});
        tbl.push_back('{mk(1,1,3,0,0,3,1,1,0,0,1,1,0), 4'b1100, "lu_rdy_req"});
        tbl.push_back('{mk(1,1,3,0,0,3,0,1,0,0,0,0,0), 4'b0000, "no_wb"});
        tbl.push_back('{mk(1,1,1,9,0,9,1,1,0,0,0,0,0), 4'b0000, "src2_unused"});
        tbl.push_back('{mk(1,1,1,9,1,9,1,1,0,0,0,0,0), 4'b1100, "src2_used"});
        tbl.push_back('{mk(0,1,4,4,1,1,1,0,2,1,0,0,0), 4'b0000, "nofwd_miss"});
        foreach (tbl[k]) begin
            step(tbl[k].i, ctl);
            chk(tbl[k].name, int'(ctl), int'(tbl[k].exp));
        end

        // Load-use gives exactly one bubble
        do_reset();
        step(mk(1,1,3,0,0,3,1,1,0,0,0,0,0), ctl);
        chk("lu_cyc1", int'(ctl), 4'b1100);
        step(mk(1,1,3,0,0,0,0,0,3,1,0,0,0), ctl);
        chk("lu_cyc2", int'(ctl), 0);
        chk("lu_count", int'(hazard_stalls), 1);

        // Three-cycle SRAM wait
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(mk(1,0,0,0,0,0,0,0,0,0,1,0,0), ctl);
            chk("wait_frz", int'(ctl), 4'b0010);
        end
        step(mk(1,0,0,0,0,0,0,0,0,0,1,1,0), ctl);
        chk("wait_rel", int'(ctl), 0);
        chk("wait_stalls", int'(mem_stalls), 3);
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0), ctl);
        chk("back_run", int'(ctl), 0);
        step(mk(1,0,0,0,0,0,0,0,0,0,1,1,0), ctl);
        chk("fast_sram", int'(ctl), 0);

        // Branch + load-use during an SRAM wait
        do_reset();
        lu = mk(1,1,3,0,0,3,1,1,0,0,1,0,1);
        step(lu, ctl);
        chk("br_frz1", int'(ctl), 4'b0010);
        step(lu, ctl);
        chk("br_frz2", int'(ctl), 4'b0010);
        lu.rdy = 1'b1;
        step(lu, ctl);
        chk("br_after", int'(ctl), 4'b0001);

        // Timeout after four wait cycles, sticky until reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(mk(1,0,0,0,0,0,0,0,0,0,1,0,0), ctl);
        end
        chk("to_early", int'(mem_timeout), 0);
        step(mk(1,0,0,0,0,0,0,0,0,0,1,0,0), ctl);
        chk("to_set", int'(mem_timeout), 1);
        step(mk(1,0,0,0,0,0,0,0,0,0,1,1,0), ctl);
        chk("to_rel_frz", int'(ctl), 0);
        chk("to_sticky", int'(mem_timeout), 1);
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0), ctl);
        chk("to_sticky2", int'(mem_timeout), 1);
        do_reset();
        chk("to_clear", int'(mem_timeout), 0);

        // Reset in the middle of a wait
        step(mk(1,0,0,0,0,0,0,0,0,0,1,0,0), ctl);
        step(mk(1,0,0,0,0,0,0,0,0,0,1,0,0), ctl);
        v = mk(1,0,0,0,0,0,0,0,0,0,1,0,0);
        v.rst = 1'b1;
        step(v, ctl);
        chk("mid_rst_frz", int'(ctl), 0);
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0), ctl);
        chk("mid_rst_run", int'(ctl), 0);
        chk("mid_rst_cnt", int'(mem_stalls), 0);

        // Saturation of the hazard counter
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(mk(1,1,3,0,0,3,1,1,0,0,0,0,0), ctl);
        end
        chk("hz_sat", int'(hazard_stalls), CMAX);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            v     = '0;
            v.rst = ($urandom_range(0, 59) == 0);
            v.fwd = 1'($urandom);
            v.idv = ($urandom_range(0, 3) != 0);
            v.s1  = AW'($urandom_range(0, 3));
            v.s2  = AW'($urandom_range(0, 3));
            v.two = 1'($urandom);
            v.ed  = AW'($urandom_range(0, 3));
            v.ewb = 1'($urandom);
            v.eld = 1'($urandom);
            v.md  = AW'($urandom_range(0, 3));
            v.mwb = 1'($urandom);
            v.req = ($urandom_range(0, 2) == 0);
            v.rdy = ($urandom_range(0, 4) == 0);
            v.br  = ($urandom_range(0, 7) == 0);
            step(v, ctl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
